// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// write-first forwarding and a self-clear after reset. Define RAM_PARITY_EN for per-byte parity.
module ram_dp_be #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
`ifdef RAM_PARITY_EN
  output logic [DATA_WIDTH/8-1:0] parity_err,
`endif
  output logic                    init_done
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH/8;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("ram_dp_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("ram_dp_be: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_init_done;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [NBYTES-1:0]     w_mem_wbe;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [NBYTES-1:0]     w_fwd;

  assign w_wr_acc  = (r_state == S_READY) && wr_en;
  assign w_rd_acc  = (r_state == S_READY) && rd_en;
  assign init_done = r_init_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state     <= S_READY;
            r_init_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The clear sequence owns the write port until the array is fully zeroed.
  always_comb begin
    w_mem_we    = w_wr_acc;
    w_mem_waddr = wr_addr;
    w_mem_wdata = wr_data;
    w_mem_wbe   = wr_be;
    if (r_state == S_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_cnt;
      w_mem_wdata = '0;
      w_mem_wbe   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_mem_wbe[i]) r_mem[w_mem_waddr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_rd_word = r_mem[rd_addr];
    w_fwd     = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (w_wr_acc && (wr_addr == rd_addr) && wr_be[i]) begin
        w_fwd[i]              = 1'b1;
        w_rd_word[8*i +: 8]   = wr_data[8*i +: 8];
      end
    end
  end

`ifdef RAM_PARITY_EN
  function automatic logic f_even_par(input logic [7:0] b);
    return ^b;
  endfunction

  logic [NBYTES-1:0] r_par [DEPTH];
  logic [NBYTES-1:0] w_perr;
  logic [NBYTES-1:0] r_perr_p0;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_mem_wbe[i]) r_par[w_mem_waddr][i] <= f_even_par(w_mem_wdata[8*i +: 8]);
      end
    end
  end

  always_comb begin
    w_perr = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w_perr[i] = !w_fwd[i] && (f_even_par(r_mem[rd_addr][8*i +: 8]) != r_par[rd_addr][i]);
    end
  end
`endif

  // Stage p0: array read with write-first merge
  logic                  r_vld_p0;
  logic [DATA_WIDTH-1:0] r_rd_data_p0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p0     <= 1'b0;
      r_rd_data_p0 <= '0;
`ifdef RAM_PARITY_EN
      r_perr_p0    <= '0;
`endif
    end else begin
      r_vld_p0 <= w_rd_acc;
      if (w_rd_acc) r_rd_data_p0 <= w_rd_word;
`ifdef RAM_PARITY_EN
      r_perr_p0 <= w_rd_acc ? w_perr : '0;
`endif
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      // Stage p1: plain output register
      logic                  r_vld_p1;
      logic [DATA_WIDTH-1:0] r_rd_data_p1;
`ifdef RAM_PARITY_EN
      logic [NBYTES-1:0]     r_perr_p1;
`endif
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_vld_p1     <= 1'b0;
          r_rd_data_p1 <= '0;
`ifdef RAM_PARITY_EN
          r_perr_p1    <= '0;
`endif
        end else begin
          r_vld_p1 <= r_vld_p0;
          if (r_vld_p0) r_rd_data_p1 <= r_rd_data_p0;
`ifdef RAM_PARITY_EN
          r_perr_p1 <= r_perr_p0;
`endif
        end
      end
      assign rd_valid   = r_vld_p1;
      assign rd_data    = r_rd_data_p1;
`ifdef RAM_PARITY_EN
      assign parity_err = r_perr_p1;
`endif
    end else begin : g_lat1
      assign rd_valid   = r_vld_p0;
      assign rd_data    = r_rd_data_p0;
`ifdef RAM_PARITY_EN
      assign parity_err = r_perr_p0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Randomized bench for ram_dp_be: latency-1 and latency-2 instances share stimulus and
// are checked against an array/history reference model. RAM_PARITY_EN adds parity checks.
module tb_ram_dp_be;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = DW/8;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2, init_done1, init_done2;
`ifdef RAM_PARITY_EN
  logic [NB-1:0] perr1, perr2;
`endif

  ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1),
`ifdef RAM_PARITY_EN
    .parity_err(perr1),
`endif
    .init_done(init_done1));

  ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2),
`ifdef RAM_PARITY_EN
    .parity_err(perr2),
`endif
    .init_done(init_done2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: word array, per-byte "corrupted" flags, and a short history of
  // read results indexed by the clock edge that accepted the read.
  logic [DW-1:0] m_mem [DEPTH];
  logic [NB-1:0] m_bad [DEPTH];
  logic          hist_vld  [4];
  logic [DW-1:0] hist_data [4];
  logic [NB-1:0] hist_err  [4];
  logic [DW-1:0] last1, last2;
  int            n_edge = 0;
  int            cyc    = 0;

  task automatic model_edge();
    int            s;
    logic [DW-1:0] w;
    logic [NB-1:0] e;
    cyc++;
    s = cyc % 4;
    if (!rstn) begin
      n_edge = 0;
      last1  = '0;
      last2  = '0;
      for (int k = 0; k < 4; k++) hist_vld[k] = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        m_mem[a] = '0;
        m_bad[a] = '0;
      end
      return;
    end
    hist_vld[s] = 1'b0;
    if (n_edge >= DEPTH) begin
      if (rd_en) begin
        w = m_mem[rd_addr];
        e = m_bad[rd_addr];
        if (wr_en && wr_addr == rd_addr) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
              w[8*b +: 8] = wr_data[8*b +: 8];
              e[b] = 1'b0;
            end
          end
        end
        hist_vld[s]  = 1'b1;
        hist_data[s] = w;
        hist_err[s]  = e;
      end
      if (wr_en) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) begin
            m_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            m_bad[wr_addr][b] = 1'b0;
          end
        end
      end
    end
    n_edge++;
    if (hist_vld[s]) last1 = hist_data[s];
    if (hist_vld[(cyc + 3) % 4]) last2 = hist_data[(cyc + 3) % 4];
  endtask

  task automatic check_outputs();
    int s1;
    int s2;
    s1 = cyc % 4;
    s2 = (cyc + 3) % 4;
    check("init_done_l1", init_done1, n_edge >= DEPTH);
    check("init_done_l2", init_done2, n_edge >= DEPTH);
    check("rd_valid_l1", rd_valid1, hist_vld[s1]);
    check("rd_valid_l2", rd_valid2, hist_vld[s2]);
    check("rd_data_l1", rd_data1, last1);
    check("rd_data_l2", rd_data2, last2);
`ifdef RAM_PARITY_EN
    check("parity_err_l1", perr1, hist_vld[s1] ? hist_err[s1] : '0);
    check("parity_err_l2", perr2, hist_vld[s2] ? hist_err[s2] : '0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic rand_inputs();
    wr_en   = 1'($urandom_range(0, 1));
    wr_addr = AW'($urandom_range(0, DEPTH-1));
    wr_data = $urandom;
    wr_be   = NB'($urandom_range(0, (1 << NB) - 1));
    rd_en   = 1'($urandom_range(0, 1));
    rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH-1));
  endtask

  task automatic write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    repeat (3) step();
    rstn = 1'b1;
    // Clear phase with busy inputs that must be ignored.
    repeat (DEPTH) begin
      rand_inputs();
      step();
    end
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
      check("clear_l1", rd_data1, 32'h0);
    end
    idle();
    repeat (2) step();

    // Byte-enable merge.
    write(3, 32'hDEADBEEF, 4'hF); step();
    write(3, 32'h11223344, 4'b0101); step();
    idle(); rd_en = 1'b1; rd_addr = 3; step();
    check("be_merge_l1", rd_data1, 32'hDE22BE44);
    idle(); step();
    check("be_merge_vld_l2", rd_valid2, 1'b1);
    check("be_merge_l2", rd_data2, 32'hDE22BE44);

    // Write-first forwarding on a partial write.
    write(5, 32'h12345678, 4'hF); step();
    write(5, 32'hAAAAAAAA, 4'b0011); rd_en = 1'b1; rd_addr = 5; step();
    check("fwd_l1", rd_data1, 32'h1234AAAA);
    idle(); step();
    check("fwd_l2", rd_data2, 32'h1234AAAA);

    // No-op write with all byte enables low.
    write(5, 32'hFFFFFFFF, 4'b0000); step();
    idle(); rd_en = 1'b1; rd_addr = 5; step();
    idle(); step();
    check("be_zero_l2", rd_data2, 32'h1234AAAA);

    // Back-to-back burst; latency-2 write right after the read must not leak through.
    for (int a = 0; a < 4; a++) begin
      write(a, $urandom, 4'hF); step();
    end
    idle();
    for (int a = 0; a < 4; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      if (a == 1) write(0, 32'hCAFEF00D, 4'hF); else wr_en = 1'b0;
      step();
    end
    idle();
    repeat (3) step();

    // Reset one cycle after a read: latency-2 result is dropped, clear repeats.
    write(9, 32'h5A5A5A5A, 4'hF); step();
    idle(); rd_en = 1'b1; rd_addr = 9; step();
    idle(); rstn = 1'b0; step();
    check("rst_drop_vld_l2", rd_valid2, 1'b0);
    check("rst_data_l2", rd_data2, 32'h0);
    rstn = 1'b1;
    repeat (DEPTH) begin
      rand_inputs();
      step();
    end
    idle(); rd_en = 1'b1; rd_addr = 9; step();
    check("reclear_l1", rd_data1, 32'h0);
    idle(); step();

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      if ($urandom_range(0, 599) == 0) begin
        idle(); rstn = 1'b0; step(); step(); rstn = 1'b1;
      end
      rand_inputs();
      step();
    end
    idle();
    repeat (DEPTH + 2) step();

`ifdef RAM_PARITY_EN
    write(7, $urandom, 4'hF); step();
    idle();
    u_dut1.r_mem[7][9] <= ~u_dut1.r_mem[7][9];
    u_dut2.r_mem[7][9] <= ~u_dut2.r_mem[7][9];
    m_mem[7][9] = ~m_mem[7][9];
    m_bad[7][1] = 1'b1;
    step();
    rd_en = 1'b1; rd_addr = 7; step();
    check("parity_flip_l1", perr1, 4'b0010);
    idle(); step();
    check("parity_flip_l2", perr2, 4'b0010);
    write(7, 32'h00FF0000, 4'b0010); rd_en = 1'b1; rd_addr = 7; step();
    check("parity_fwd_l1", perr1, 4'b0000);
    idle(); step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
